// File: rtl/fifo_pkg.sv
// Shared definitions for the bridge-datapath FIFOs: read-mode selectors,
// FWFT output-stage state encodings and an elaboration-time depth check.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    typedef enum logic [1:0] {
        FWFT_EMPTY  = 2'd0,
        FWFT_HEAD   = 2'd1,
        FWFT_STREAM = 2'd2
    } fwft_state_t;

    function automatic bit is_pow2_depth(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: one synchronous write port and one synchronous read
// port with read enable; the read register holds its value while re is low.
module fifo_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // NOTE: the array and its read register carry no reset so they map onto
    // block RAM; control logic around it guarantees stale words are never used.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fsfifo_ctl.sv
// Single-clock FIFO with selectable standard / first-word-fall-through read,
// run-time almost flags and sticky overflow/underflow error flags.
module fsfifo_ctl
    import fifo_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    parameter  int FWFT  = FIFO_MODE_STD,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      filled_o,
    input  logic [AW:0]      afull_thresh_i,
    input  logic [AW:0]      aempty_thresh_i,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic             overflow_o,
    output logic             underflow_o,
    input  logic             clear_err_i
);

    if (!is_pow2_depth(DEPTH)) begin : g_bad_depth
        $error("fsfifo_ctl: DEPTH must be a power of two and at least 2");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("fsfifo_ctl: FWFT must be 0 or 1");
    end

    localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr, rd_ptr_nxt, count, ram_used;
    logic             wr_acc, rd_acc;
    logic             ram_we, ram_rd_adv, ram_re;
    logic [WIDTH-1:0] ram_q, fwd_data, head_src;
    logic             fwd_sel;
    fwft_state_t      state;

    assign full_o         = (count == CAP);
    assign empty_o        = (count == '0);
    assign filled_o       = count;
    assign almost_full_o  = (count >= afull_thresh_i);
    assign almost_empty_o = (count <= aempty_thresh_i);

    assign wr_acc   = wr_i && !full_o;
    assign rd_acc   = rd_i && !empty_o;
    assign ram_used = wr_ptr - rd_ptr;

    // NOTE: every output of a combinational block gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        ram_we     = wr_acc;
        ram_rd_adv = rd_acc;
        if (FWFT == FIFO_MODE_FWFT) begin
            ram_we     = wr_acc && !((state == FWFT_EMPTY) ||
                                     (state == FWFT_HEAD && rd_acc));
            ram_rd_adv = rd_acc && (state == FWFT_STREAM);
        end
    end

    // The RAM is addressed one step ahead, so its output always shows the
    // current head word; a write landing on that address is forwarded instead.
    assign rd_ptr_nxt = ram_rd_adv ? rd_ptr + 1'b1 : rd_ptr;
    assign ram_re     = ram_we || ram_rd_adv;
    assign head_src   = fwd_sel ? fwd_data : ram_q;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i (clk_i),
        .we    (ram_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data_i),
        .re    (ram_re),
        .raddr (rd_ptr_nxt[AW-1:0]),
        .rdata (ram_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            fwd_sel     <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (ram_we)     wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_nxt;
            if (wr_acc && !rd_acc)      count <= count + 1'b1;
            else if (!wr_acc && rd_acc) count <= count - 1'b1;
            if (ram_re) begin
                fwd_sel <= ram_we && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]);
            end
            if (clear_err_i) begin
                overflow_o  <= 1'b0;
                underflow_o <= 1'b0;
            end else begin
                if (wr_i && full_o)  overflow_o  <= 1'b1;
                if (rd_i && empty_o) underflow_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_re) begin
            fwd_data <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= FWFT_EMPTY;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else if (FWFT == FIFO_MODE_FWFT) begin
            case (state)
                FWFT_EMPTY: begin
                    if (wr_acc) begin
                        rd_data_o  <= wr_data_i;
                        rd_valid_o <= 1'b1;
                        state      <= FWFT_HEAD;
                    end
                end
                FWFT_HEAD: begin
                    if (rd_acc && wr_acc) begin
                        rd_data_o <= wr_data_i;
                    end else if (rd_acc) begin
                        rd_valid_o <= 1'b0;
                        state      <= FWFT_EMPTY;
                    end else if (wr_acc) begin
                        state <= FWFT_STREAM;
                    end
                end
                FWFT_STREAM: begin
                    if (rd_acc) begin
                        rd_data_o <= head_src;
                        if (!wr_acc && ram_used == (AW + 1)'(1)) begin
                            state <= FWFT_HEAD;
                        end
                    end
                end
                default: begin
                    state      <= FWFT_EMPTY;
                    rd_valid_o <= 1'b0;
                end
            endcase
        end else begin
            rd_valid_o <= rd_acc;
            if (rd_acc) begin
                rd_data_o <= head_src;
            end
        end
    end

endmodule

// File: tb/tb_fsfifo_ctl.sv
// Drives a standard-mode and an FWFT-mode fsfifo_ctl with identical stimulus
// and checks both against a queue model every cycle plus literal expectations.
module tb_fsfifo_ctl;

    localparam int W = 32;
    localparam int D = 16;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         reset, wr, rd, clr;
    logic [W-1:0] wd;
    logic [A:0]   afull, aempty;

    logic [W-1:0] s_data, f_data;
    logic         s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic         f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [A:0]   s_filled, f_filled;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [W-1:0] q[$];
    logic [W-1:0] std_data;
    bit           std_valid, m_ovf, m_unf;

    always #5 clk = ~clk;

    fsfifo_ctl #(.WIDTH(W), .DEPTH(D), .FWFT(0)) dut_std (
        .clk_i(clk), .reset_i(reset), .wr_i(wr), .wr_data_i(wd), .rd_i(rd),
        .rd_data_o(s_data), .rd_valid_o(s_valid), .full_o(s_full),
        .empty_o(s_empty), .filled_o(s_filled), .afull_thresh_i(afull),
        .aempty_thresh_i(aempty), .almost_full_o(s_af), .almost_empty_o(s_ae),
        .overflow_o(s_ovf), .underflow_o(s_unf), .clear_err_i(clr)
    );

    fsfifo_ctl #(.WIDTH(W), .DEPTH(D), .FWFT(1)) dut_fwft (
        .clk_i(clk), .reset_i(reset), .wr_i(wr), .wr_data_i(wd), .rd_i(rd),
        .rd_data_o(f_data), .rd_valid_o(f_valid), .full_o(f_full),
        .empty_o(f_empty), .filled_o(f_filled), .afull_thresh_i(afull),
        .aempty_thresh_i(aempty), .almost_full_o(f_af), .almost_empty_o(f_ae),
        .overflow_o(f_ovf), .underflow_o(f_unf), .clear_err_i(clr)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Word-level model: a FIFO of at most D words, shared by both read modes.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            std_valid = 1'b0;
            std_data  = '0;
            m_ovf     = 1'b0;
            m_unf     = 1'b0;
        end else begin
            bit is_full, is_empty;
            is_full  = (q.size() == D);
            is_empty = (q.size() == 0);
            if (clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                if (wr && is_full)  m_ovf = 1'b1;
                if (rd && is_empty) m_unf = 1'b1;
            end
            std_valid = rd && !is_empty;
            if (std_valid) std_data = q.pop_front();
            if (wr && !is_full) q.push_back(wd);
        end
    end

    always @(negedge clk) begin : cmp
        int n;
        if (chk_en) begin
            n = q.size();
            check("s_filled", s_filled, n);
            check("f_filled", f_filled, n);
            check("s_full", s_full, n == D);
            check("f_full", f_full, n == D);
            check("s_empty", s_empty, n == 0);
            check("f_empty", f_empty, n == 0);
            check("s_afull", s_af, n >= int'(afull));
            check("f_afull", f_af, n >= int'(afull));
            check("s_aempty", s_ae, n <= int'(aempty));
            check("f_aempty", f_ae, n <= int'(aempty));
            check("s_ovf", s_ovf, m_ovf);
            check("f_ovf", f_ovf, m_ovf);
            check("s_unf", s_unf, m_unf);
            check("f_unf", f_unf, m_unf);
            check("s_valid", s_valid, std_valid);
            check("s_data", s_data, std_data);
            check("f_valid", f_valid, n != 0);
            if (n != 0) check("f_head", f_data, q[0]);
        end
    end

    task automatic cyc(input logic w, input logic [W-1:0] d, input logic r,
                       input logic c = 1'b0);
        wr = w; wd = d; rd = r; clr = c;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0; wd = '0;
        afull = 5'd12; aempty = 5'd3;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        check("rst_filled", s_filled, 0);
        check("rst_empty", f_empty, 1);
        check("rst_full", s_full, 0);
        check("rst_sdata", s_data, 0);
        check("rst_valid", {s_valid, f_valid}, 0);

        // Fill to capacity, crossing the almost-full threshold at 12.
        for (int i = 0; i < D; i++) begin
            cyc(1'b1, W'(i), 1'b0);
            if (i == 0)  check("fwft_first", f_data, 0);
            if (i == 10) check("af_at_11", s_af, 0);
            if (i == 11) check("af_at_12", f_af, 1);
        end
        cyc(1'b1, 32'd99, 1'b0);
        check("full_lit", s_full, 1);
        check("ovf_lit", f_ovf, 1);
        check("filled16", f_filled, 16);

        // Drain with an idle cycle between reads to show pulse and hold.
        for (int i = 0; i < D; i++) begin
            cyc(1'b0, '0, 1'b1);
            check("std_rd_val", s_valid, 1);
            check("std_rd_data", s_data, i);
            if (i == 11) check("ae_at_4", s_ae, 0);
            if (i == 12) check("ae_at_3", f_ae, 1);
            cyc(1'b0, '0, 1'b0);
            check("std_pulse", s_valid, 0);
            check("std_hold", s_data, i);
        end
        check("drained", s_empty, 1);

        // Underflow is sticky; clear wins over a same-cycle bad read.
        cyc(1'b0, '0, 1'b1);
        check("unf_set", s_unf, 1);
        cyc(1'b0, '0, 1'b0);
        check("unf_sticky", f_unf, 1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        check("unf_clr", {s_unf, f_unf, s_ovf, f_ovf}, 0);

        // FWFT single word fall-through, then pop.
        cyc(1'b1, 32'hA5, 1'b0);
        check("a5_data", f_data, 32'hA5);
        check("a5_valid", f_valid, 1);
        cyc(1'b0, '0, 1'b1);
        check("a5_empty", f_empty, 1);
        check("a5_fvalid", f_valid, 0);
        check("a5_std", s_data, 32'hA5);

        // Streaming from empty (bypass path), then with two words buffered.
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 32'h100 + W'(i), 1'b1);
            check("stream1_fill", f_filled, 1);
        end
        cyc(1'b1, 32'h200, 1'b0);
        cyc(1'b1, 32'h201, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 32'h300 + W'(i), 1'b1);
            check("stream3_fill", s_filled, 3);
        end
        check("stream3_head", f_data, 32'h300 + 37);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);

        // Mixed traffic with moving thresholds; reaches full with pops.
        for (int i = 0; i < 64; i++) begin
            afull  = 5'((i % 17));
            aempty = 5'(((i * 3) % 17));
            cyc(i % 4 != 3, 32'h400 + W'(i), i % 3 == 0);
        end
        afull = 5'd12; aempty = 5'd3;
        for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b1);

        // Reset mid-burst with 7 words held and errors set.
        for (int i = 0; i < 7; i++) cyc(1'b1, 32'h500 + W'(i), 1'b0);
        reset = 1'b1;
        cyc(1'b1, 32'hDEAD, 1'b1);
        reset = 1'b0;
        check("mrst_filled", f_filled, 0);
        check("mrst_empty", s_empty, 1);
        check("mrst_valid", {s_valid, f_valid}, 0);
        check("mrst_err", {s_ovf, s_unf, f_ovf, f_unf}, 0);

        // 50 words round-trip across the pointer wrap.
        for (int i = 0; i < 60; i++) begin
            cyc(i < 50, 32'd1000 + W'(i), i >= 5);
        end
        check("wrap_last", s_data, 1049);
        check("wrap_empty", f_empty, 1);
        check("wrap_unf", s_unf, 1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsfifo_ctl.md
# fsfifo_ctl

Second-generation single-clock FIFO for the bridge datapath. Generalises the plain synchronous FIFO with a selectable first-word-fall-through (FWFT) read mode, run-time almost-full/almost-empty thresholds, a read-valid strobe, and sticky overflow/underflow error flags. It sits between the SQT56 packet framer and the downstream bus interface, wherever back-pressure visibility ahead of a hard full is required.

## Interface
Parameters:
- WIDTH, 32, data word width in bits (≥1).
- DEPTH, 16, capacity in words; power of two, ≥2; any other value is an elaboration error.
- FWFT, 0, 0 = standard mode (data after read request); 1 = first-word-fall-through.

Ports (AW = $clog2(DEPTH)):
- clk_i  in  1  single clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- wr_i  in  1  write request.
- wr_data_i  in  WIDTH  write data.
- rd_i  in  1  read request (standard mode) / pop head word (FWFT mode).
- rd_data_o  out  WIDTH  read data, registered.
- rd_valid_o  out  1  rd_data_o holds a freshly read word (standard) / a head word is present (FWFT).
- full_o  out  1  filled_o == DEPTH.
- empty_o  out  1  filled_o == 0.
- filled_o  out  AW+1  words held, including the FWFT output register.
- afull_thresh_i  in  AW+1  almost-full threshold.
- aempty_thresh_i  in  AW+1  almost-empty threshold.
- almost_full_o  out  1  filled_o >= afull_thresh_i (combinational).
- almost_empty_o  out  1  filled_o <= aempty_thresh_i (combinational).
- overflow_o  out  1  sticky: a write was attempted while full.
- underflow_o  out  1  sticky: a read was attempted while empty.
- clear_err_i  in  1  clears overflow_o and underflow_o.

## Operation
- Accepted write = wr_i && !full_o; accepted read = rd_i && !empty_o; both evaluated against pre-edge flags. A write while full is dropped; a read while empty does nothing.
- Capacity is exactly DEPTH words in both modes. Pointers are AW+1 bits wide and wrap modulo 2·DEPTH; filled_o tracks the total word count.
- Standard mode: an accepted read loads rd_data_o with the head word and pulses rd_valid_o for one cycle. rd_data_o holds its value until the next accepted read.
- FWFT mode: rd_data_o always shows the head word, rd_valid_o = !empty_o, and rd_i pops the head. Internal states:
  - EMPTY: output register invalid, RAM empty.
  - HEAD: output register valid, RAM empty.
  - STREAM: output register valid, RAM holds ≥1 word.
- FWFT head sourcing: a write into EMPTY, or into HEAD coincident with a pop, bypasses the RAM straight into the output register. When the RAM is non-empty, a pop refills the output register from the RAM prefetch so the next head is visible the following cycle with no bubble.
- Simultaneous accepted read and write: filled_o is unchanged. When full, only the read is accepted. When empty, only the write is accepted; this holds in FWFT too, since the bypass makes the word visible next cycle.
- Error flags: overflow_o is set by wr_i && full_o, and underflow_o by rd_i && empty_o. clear_err_i has priority over a same-cycle set. The flags remain set until clear_err_i or reset.
- Reset (any time, mid-burst included) discards contents. Pointers, count, rd_data_o, rd_valid_o and error flags go to 0, so full_o=0 and empty_o=1. RAM contents are not reset.

## Timing
- Write latency to visibility:
  - Standard mode: data written at edge N is readable by a read at edge N+1.
  - FWFT mode, write into EMPTY at edge N: rd_valid_o=1 and rd_data_o valid after edge N.
- Read latency, standard mode: read accepted at edge N gives rd_data_o/rd_valid_o valid after edge N (one cycle).
- full_o, empty_o and filled_o update on the edge following the accepted operation.
- Almost flags are combinational from filled_o and the threshold inputs; thresholds may change any cycle.
- Sustained throughput is one write plus one read per cycle in both modes.

## Structure
- Shared package fifo_pkg: FIFO_MODE_STD / FIFO_MODE_FWFT constants and the FWFT state encodings.
- Sub-module fifo_ram: simple dual-port RAM, DEPTH×WIDTH, synchronous write, synchronous read with read enable, no reset.
- Top level contains pointers, count, flag logic, the FWFT output register and its state machine.

## Test plan
- Standard mode, DEPTH=16: write 0..15, then issue a 17th write → full_o=1 and overflow_o=1; then 16 reads → rd_data_o yields 0..15, each with a one-cycle rd_valid_o, then empty_o=1.
- FWFT mode: single write of 0xA5 at edge N → after N, rd_data_o=0xA5 and rd_valid_o=1; pop → empty_o=1 next cycle.
- FWFT streaming: write and pop simultaneously every cycle for 40 cycles → in-order data, no bubble, filled_o constant.
- Thresholds: afull=12, aempty=3; fill to 11 → almost_full_o=0; at 12 → almost_full_o=1; drain to 3 → almost_empty_o=1.
- Errors: rd_i while empty → underflow_o=1 and stays set; clear_err_i asserted together with another bad read → flag ends 0.
- Reset with 7 words held, in both modes → next cycle filled_o=0, empty_o=1, rd_valid_o=0, error flags 0; a subsequent write/read round-trips correctly across pointer wrap (≥40 words).
